// File: rtl/hwpe_ctrl_loop_seq.sv
// Nested hardware-loop sequencer: walks NB_LOOPS nested index counters
// (loop 0 innermost) under a valid/ready handshake. Ranges and the loop
// count are latched at start.
module hwpe_ctrl_loop_seq #(
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned CNT_WIDTH = 12,
  localparam int unsigned NLW      = $clog2(NB_LOOPS + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [NLW-1:0]                nb_loops_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0] range_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0] idx_o,
  output logic [NB_LOOPS-1:0]           wrap_o,
  output logic                          busy_o,
  output logic                          done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                                 state_q, state_d;
  logic [NLW-1:0]                         nb_loops_q, nb_loops_d;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]     range_q, range_d;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]     idx_q, idx_d;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]     range_in;
  logic [NB_LOOPS-1:0]                    active;
  logic [NB_LOOPS-1:0]                    wrap;
  logic                                   last_wrap;
  logic                                   match;
  logic                                   empty;
  logic                                   carry;
  logic                                   valid;

  assign range_in = range_i;
  assign valid    = (state_q == RUN);

  assign valid_o  = valid;
  assign idx_o    = idx_q;
  assign wrap_o   = wrap;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);

  // Per-loop activity and wrap flags; last_wrap marks the final tuple of the job
  always_comb begin
    match     = 1'b1;
    last_wrap = 1'b0;
    active    = '0;
    wrap      = '0;
    for (int k = 0; k < NB_LOOPS; k++) begin
      active[k] = (NLW'(k) < nb_loops_q);
      match     = match & (idx_q[k] == range_q[k] - CNT_WIDTH'(1));
      wrap[k]   = valid & active[k] & match;
      if (NLW'(k + 1) == nb_loops_q) last_wrap = wrap[k];
    end
  end

  // A job is empty when no loop is active or any active loop has zero range
  always_comb begin
    empty = (nb_loops_i == '0);
    for (int k = 0; k < NB_LOOPS; k++) begin
      if ((NLW'(k) < nb_loops_i) && (range_in[k] == '0)) empty = 1'b1;
    end
  end

  // Next-state, config latch and ripple-carry index update
  always_comb begin
    state_d    = state_q;
    nb_loops_d = nb_loops_q;
    range_d    = range_q;
    idx_d      = idx_q;
    carry      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          nb_loops_d = nb_loops_i;
          range_d    = range_in;
          idx_d      = '0;
          state_d    = empty ? DONE : RUN;
        end
      end
      RUN: begin
        if (ready_i) begin
          carry = 1'b1;
          for (int k = 0; k < NB_LOOPS; k++) begin
            if (active[k] && carry) begin
              if (idx_q[k] == range_q[k] - CNT_WIDTH'(1)) begin
                idx_d[k] = '0;
              end else begin
                idx_d[k] = idx_q[k] + CNT_WIDTH'(1);
                carry    = 1'b0;
              end
            end
          end
          if (last_wrap) begin
            idx_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Soft clear wins over start and handshake
    if (clear_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // State, configuration and index registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      nb_loops_q <= '0;
      range_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      nb_loops_q <= nb_loops_d;
      range_q    <= range_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_loop_seq.sv
// Directed testbench for hwpe_ctrl_loop_seq (NB_LOOPS=6, CNT_WIDTH=12).
module tb_hwpe_ctrl_loop_seq;

  localparam int unsigned NL = 6;
  localparam int unsigned CW = 12;

  logic            clk;
  logic            rst;
  logic            clear;
  logic            start;
  logic [2:0]      nb_loops;
  logic [NL*CW-1:0] range_v;
  logic            ready;
  logic            valid;
  logic [NL*CW-1:0] idx;
  logic [NL-1:0]   wrap;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  hwpe_ctrl_loop_seq #(.NB_LOOPS(NL), .CNT_WIDTH(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .start_i    (start),
    .nb_loops_i (nb_loops),
    .range_i    (range_v),
    .ready_i    (ready),
    .valid_o    (valid),
    .idx_o      (idx),
    .wrap_o     (wrap),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack loop-0 and loop-1 values into a full NB_LOOPS x CNT_WIDTH vector
  function automatic logic [NL*CW-1:0] tup(input int a, input int b);
    logic [NL*CW-1:0] t;
    t = '0;
    t[CW-1:0]    = CW'(a);
    t[2*CW-1:CW] = CW'(b);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] n, input logic [NL*CW-1:0] r);
    nb_loops = n;
    range_v  = r;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({valid, busy, done, wrap, idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b b=%0b d=%0b w=%b idx=%h want all 0",
               valid, busy, done, wrap, idx);
    end
  endtask

  task automatic test_nominal();
    int          l0 [6] = '{0, 1, 2, 0, 1, 2};
    int          l1 [6] = '{0, 0, 0, 1, 1, 1};
    logic [NL-1:0] w [6] = '{6'b00, 6'b00, 6'b01, 6'b00, 6'b00, 6'b11};
    ready = 1'b1;
    launch(3'd2, tup(3, 2));
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (valid !== 1'b1 || idx !== tup(l0[i], l1[i]) || wrap !== w[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL nominal_tuple%0d got v=%0b idx=%h w=%b d=%0b want v=1 idx=%h w=%b d=0",
                 i + 1, valid, idx, wrap, done, tup(l0[i], l1[i]), w[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1 || idx !== '0) begin
      errors++;
      $display("FAIL nominal_done got d=%0b v=%0b b=%0b idx=%h want d=1 v=0 b=1 idx=0",
               done, valid, busy, idx);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal_idle got d=%0b b=%0b want d=0 b=0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    launch(3'd2, tup(3, 2));
    for (int cyc = 0; cyc < 40; cyc++) begin
      checks++;
      if (valid !== 1'b1 || idx !== tup(hs % 3, hs / 3)) begin
        errors++;
        $display("FAIL backpressure_hold cyc%0d got v=%0b idx=%h want v=1 idx=%h",
                 cyc, valid, idx, tup(hs % 3, hs / 3));
      end
      ready = ((cyc % 3) == 0);
      step();
      if (ready) hs++;
      if (hs == 6) break;
    end
    ready = 1'b1;
    checks++;
    if (hs !== 6 || done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_done got hs=%0d d=%0b v=%0b want hs=6 d=1 v=0", hs, done, valid);
    end
    step();
  endtask

  task automatic test_empty();
    launch(3'd2, tup(0, 4));
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_range_done got d=%0b v=%0b b=%0b want d=1 v=0 b=1", done, valid, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_range_idle got d=%0b v=%0b b=%0b want 0 0 0", done, valid, busy);
    end
    launch(3'd0, tup(3, 2));
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_nb0_done got d=%0b v=%0b want d=1 v=0", done, valid);
    end
    step();
    checks++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_nb0_idle got d=%0b v=%0b b=%0b want 0 0 0", done, valid, busy);
    end
  endtask

  task automatic test_clear();
    ready = 1'b1;
    launch(3'd2, tup(3, 2));
    // start held high in RUN must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (idx !== tup(2, 0) || valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre got idx=%h v=%0b want idx=%h v=1", idx, valid, tup(2, 0));
    end
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 || idx !== '0) begin
      errors++;
      $display("FAIL clear_idle got b=%0b v=%0b d=%0b idx=%h want 0 0 0 0", busy, valid, done, idx);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_done got b=%0b d=%0b want 0 0", busy, done);
    end
    launch(3'd2, tup(3, 2));
    checks++;
    if (idx !== '0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_restart got idx=%h v=%0b want idx=0 v=1", idx, valid);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    int l0 [4] = '{0, 1, 0, 1};
    int l1 [4] = '{0, 0, 1, 1};
    ready = 1'b1;
    launch(3'd2, tup(3, 2));
    step();
    range_v = tup(7, 7);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({valid, busy, done, wrap, idx} !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%0b b=%0b d=%0b w=%b idx=%h want all 0",
               valid, busy, done, wrap, idx);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    launch(3'd2, tup(2, 2));
    range_v = tup(5, 5);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (valid !== 1'b1 || idx !== tup(l0[i], l1[i])) begin
        errors++;
        $display("FAIL latched_cfg_tuple%0d got v=%0b idx=%h want v=1 idx=%h",
                 i + 1, valid, idx, tup(l0[i], l1[i]));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL latched_cfg_done got d=%0b v=%0b want d=1 v=0", done, valid);
    end
    step();
  endtask

  task automatic test_max_range();
    logic [NL-1:0] ew;
    ready = 1'b1;
    launch(3'd1, tup(4095, 9));
    for (int i = 0; i < 4095; i++) begin
      ew = (i == 4094) ? 6'b000001 : 6'b000000;
      checks++;
      if (valid !== 1'b1 || idx !== tup(i, 0) || wrap !== ew) begin
        errors++;
        $display("FAIL max_range_hs%0d got v=%0b idx=%h w=%b want v=1 idx=%h w=%b",
                 i, valid, idx, wrap, tup(i, 0), ew);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || idx !== '0) begin
      errors++;
      $display("FAIL max_range_done got d=%0b v=%0b idx=%h want d=1 v=0 idx=0", done, valid, idx);
    end
    step();
  endtask

  initial begin
    rst      = 1'b1;
    clear    = 1'b0;
    start    = 1'b0;
    ready    = 1'b0;
    nb_loops = '0;
    range_v  = '0;
    #2;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    test_nominal();
    test_backpressure();
    test_empty();
    test_clear();
    test_async_reset();
    test_max_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
